// File: rtl/requant_pkg.sv
// Shared widths, channel config record, FSM states and output saturation for conv_requant_relu.
// RELU_EN selects the clamp range: 0..127 when defined, -128..127 otherwise.
package requant_pkg;

    localparam int unsigned ACC_W   = 32;
    localparam int unsigned WI      = 8;
    localparam int unsigned MULT_W  = 16;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned TOT_W   = 27;
    localparam int unsigned S1_W    = ACC_W + 1;
    localparam int unsigned S2_W    = S1_W + MULT_W + 1;
    localparam int unsigned R_W     = S2_W + 1;

    typedef struct packed {
        logic [ACC_W-1:0]   bias;
        logic [MULT_W-1:0]  mult;
        logic [SHIFT_W-1:0] shift;
    } ch_cfg_t;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic signed [R_W-1:0] SatHi = R_W'((2 ** (WI - 1)) - 1);
`ifdef RELU_EN
    localparam logic signed [R_W-1:0] SatLo = '0;
`else
    localparam logic signed [R_W-1:0] SatLo = ~SatHi;
`endif

    function automatic logic signed [WI-1:0] saturate(input logic signed [R_W-1:0] r);
        if (r > SatHi) begin
            return WI'(SatHi);
        end else if (r < SatLo) begin
            return WI'(SatLo);
        end
        return WI'(r);
    endfunction

endpackage

// File: rtl/requant_cfg_ram.sv
// Per-output-channel config register file: synchronous write, combinational read.
module requant_cfg_ram
    import requant_pkg::*;
#(
    parameter int unsigned MAX_CH = 64,
    parameter int unsigned CH_AW  = $clog2(MAX_CH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [CH_AW-1:0] waddr_i,
    input  ch_cfg_t          wdata_i,
    input  logic [CH_AW-1:0] raddr_i,
    output ch_cfg_t          rdata_o
);

    ch_cfg_t mem_q [MAX_CH];
    logic    addr_ok;

    // Out-of-range indices can only occur when MAX_CH is not a power of two.
    if (MAX_CH == (1 << CH_AW)) begin : g_full
        assign addr_ok = 1'b1;
    end else begin : g_part
        assign addr_ok = (32'(waddr_i) < MAX_CH);
    end

    always_ff @(posedge clk_i) begin
        if (we_i && addr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_requant_relu.sv
// Requantises the conv accumulator stream: bias, multiply, rounding shift, clamp; 3-cycle latency.
// RELU_EN (defined) zeroes negative results before the clamp; undefined keeps a signed clamp.
module conv_requant_relu
    import requant_pkg::*;
#(
    parameter int unsigned MAX_CH = 64,
    parameter int unsigned CH_AW  = $clog2(MAX_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ap_start,
    input  logic [8:0]               ofm_w,
    input  logic [8:0]               out_ch,
    input  logic                     cfg_we,
    input  logic [CH_AW-1:0]         cfg_ch,
    input  logic signed [ACC_W-1:0]  cfg_bias,
    input  logic [MULT_W-1:0]        cfg_mult,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic                     acc_vld_i,
    output logic signed [WI-1:0]     conv_kern_o,
    output logic                     conv_kern_vld_o,
    output logic                     busy,
    output logic                     ap_done
);

    state_e             state_q;
    logic               start_q;
    logic [8:0]         out_ch_q;
    logic [TOT_W-1:0]   total_q;
    logic [TOT_W-1:0]   total_d;
    logic [TOT_W-1:0]   in_cnt_q;
    logic [TOT_W-1:0]   out_cnt_q;
    logic [CH_AW-1:0]   ch_cnt_q;
    logic               acc_take;
    ch_cfg_t            wr_cfg;
    ch_cfg_t            rd_cfg;

    logic                     v1_q;
    logic                     v2_q;
    logic signed [S1_W-1:0]   s1_q;
    logic [MULT_W-1:0]        mult1_q;
    logic [SHIFT_W-1:0]       shift1_q;
    logic signed [S2_W-1:0]   s2_q;
    logic [SHIFT_W-1:0]       shift2_q;
    logic signed [R_W-1:0]    s2_ext;
    logic signed [R_W-1:0]    half;
    logic signed [R_W-1:0]    r_full;

    assign total_d  = TOT_W'(ofm_w) * TOT_W'(ofm_w) * TOT_W'(out_ch);
    assign acc_take = acc_vld_i && (state_q == StRun);

    assign wr_cfg.bias  = cfg_bias;
    assign wr_cfg.mult  = cfg_mult;
    assign wr_cfg.shift = cfg_shift;

    requant_cfg_ram #(
        .MAX_CH (MAX_CH),
        .CH_AW  (CH_AW)
    ) u_cfg_ram (
        .clk_i   (clk),
        .we_i    (cfg_we && (state_q == StIdle)),
        .waddr_i (cfg_ch),
        .wdata_i (wr_cfg),
        .raddr_i (ch_cnt_q),
        .rdata_o (rd_cfg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            out_ch_q  <= '0;
            total_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ch_cnt_q  <= '0;
            busy      <= 1'b0;
            ap_done   <= 1'b0;
        end else begin
            start_q <= ap_start;
            ap_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ap_start && !start_q) begin
                        total_q   <= total_d;
                        out_ch_q  <= out_ch;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        ch_cnt_q  <= '0;
                        if (total_d == '0) begin
                            state_q <= StDone;
                            ap_done <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy    <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (acc_take) begin
                        in_cnt_q <= in_cnt_q + TOT_W'(1);
                        if (9'(ch_cnt_q) == out_ch_q - 9'd1) begin
                            ch_cnt_q <= '0;
                        end else begin
                            ch_cnt_q <= ch_cnt_q + 1'b1;
                        end
                        if (in_cnt_q + TOT_W'(1) == total_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (out_cnt_q == total_q) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        ap_done <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
            // Counted as the result enters the output register, so DRAIN exits the cycle
            // the last output is visible and ap_done follows one cycle later.
            if (v2_q) begin
                out_cnt_q <= out_cnt_q + TOT_W'(1);
            end
        end
    end

    always_comb begin
        s2_ext = R_W'(s2_q);
        half   = '0;
        if (shift2_q != '0) begin
            half = R_W'(1) <<< (shift2_q - SHIFT_W'(1));
        end
        r_full = (s2_ext + half) >>> shift2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q            <= 1'b0;
            v2_q            <= 1'b0;
            conv_kern_vld_o <= 1'b0;
            conv_kern_o     <= '0;
        end else begin
            v1_q            <= acc_take;
            v2_q            <= v1_q;
            conv_kern_vld_o <= v2_q;
            if (v2_q) begin
                conv_kern_o <= saturate(r_full);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc_take) begin
            s1_q     <= S1_W'(acc_i) + S1_W'($signed(rd_cfg.bias));
            mult1_q  <= rd_cfg.mult;
            shift1_q <= rd_cfg.shift;
        end
        if (v1_q) begin
            s2_q     <= S2_W'(s1_q) * S2_W'($signed({1'b0, mult1_q}));
            shift2_q <= shift1_q;
        end
    end

endmodule

// File: tb/tb_conv_requant_relu.sv
// Directed self-checking bench for conv_requant_relu; expected values are hand-computed.
module tb_conv_requant_relu;

    logic               clk = 1'b0;
    logic               rst;
    logic               ap_start;
    logic [8:0]         ofm_w;
    logic [8:0]         out_ch;
    logic               cfg_we;
    logic [5:0]         cfg_ch;
    logic signed [31:0] cfg_bias;
    logic [15:0]        cfg_mult;
    logic [4:0]         cfg_shift;
    logic signed [31:0] acc_i;
    logic               acc_vld_i;
    logic signed [7:0]  conv_kern_o;
    logic               conv_kern_vld_o;
    logic               busy;
    logic               ap_done;

    int                 n_run = 0;
    int                 n_fail = 0;
    logic signed [31:0] last_out;

`ifdef RELU_EN
    localparam int ExpNeg7 = 0;
    localparam int ExpNeg1000 = 0;
    localparam int ExpNegRnd = 0;
`else
    localparam int ExpNeg7 = -7;
    localparam int ExpNeg1000 = -128;
    localparam int ExpNegRnd = -1;
`endif

    always #5 clk = ~clk;

    conv_requant_relu u_dut (
        .clk             (clk),
        .rst             (rst),
        .ap_start        (ap_start),
        .ofm_w           (ofm_w),
        .out_ch          (out_ch),
        .cfg_we          (cfg_we),
        .cfg_ch          (cfg_ch),
        .cfg_bias        (cfg_bias),
        .cfg_mult        (cfg_mult),
        .cfg_shift       (cfg_shift),
        .acc_i           (acc_i),
        .acc_vld_i       (acc_vld_i),
        .conv_kern_o     (conv_kern_o),
        .conv_kern_vld_o (conv_kern_vld_o),
        .busy            (busy),
        .ap_done         (ap_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input int bias, input int mult, input int shift);
        cfg_we    = 1'b1;
        cfg_ch    = 6'(ch);
        cfg_bias  = bias;
        cfg_mult  = 16'(mult);
        cfg_shift = 5'(shift);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic start_frame(input int ow, input int oc);
        ofm_w    = 9'(ow);
        out_ch   = 9'(oc);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        check("busy_run", busy, 1);
    endtask

    // Output for the input driven in cycle c is expected in cycle c+3; ap_done in cycle L+4
    // for the last accepted input L; values for channel 0/1 are e0/e1.
    task automatic run_frame(input string tag, input int acc, input logic [31:0] pat,
                             input int ncyc, input int total, input int oc,
                             input int e0, input int e1);
        int idx[32];
        int k;
        int last;
        int src;
        int exp;
        k    = 0;
        last = -1;
        for (int i = 0; i < 32; i++) begin
            if (pat[i] && k < total) begin
                idx[i] = k;
                k++;
                last = i;
            end else begin
                idx[i] = -1;
            end
        end
        for (int i = 0; i < ncyc; i++) begin
            acc_vld_i = pat[i];
            acc_i     = acc;
            step();
            src = i - 2;
            if (src >= 0 && idx[src] >= 0) begin
                exp = ((idx[src] % oc) == 0) ? e0 : e1;
                check({tag, "_vld"}, conv_kern_vld_o, 1);
                check({tag, "_data"}, conv_kern_o, exp);
                last_out = exp;
            end else begin
                check({tag, "_novld"}, conv_kern_vld_o, 0);
                check({tag, "_hold"}, conv_kern_o, last_out);
            end
            check({tag, "_done"}, ap_done, 32'(i == last + 3));
        end
        acc_vld_i = 1'b0;
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        ap_start  = 1'b0;
        ofm_w     = '0;
        out_ch    = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_bias  = '0;
        cfg_mult  = '0;
        cfg_shift = '0;
        acc_i     = '0;
        acc_vld_i = 1'b0;
        last_out  = 0;
        step();
        step();
        check("rst_out", conv_kern_o, 0);
        check("rst_vld", conv_kern_vld_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", ap_done, 0);
        rst = 1'b0;
        step();

        // Pass-through and saturation
        cfg_write(0, 0, 1, 0);
        start_frame(1, 1);
        run_frame("pass5", 5, 32'h1, 6, 1, 1, 5, 0);
        start_frame(1, 1);
        run_frame("sat_pos", 1000, 32'h1, 6, 1, 1, 127, 0);
        start_frame(1, 1);
        run_frame("neg7", -7, 32'h1, 6, 1, 1, ExpNeg7, 0);
        start_frame(1, 1);
        run_frame("sat_neg", -1000, 32'h1, 6, 1, 1, ExpNeg1000, 0);

        // Round-half-up with mult=3, shift=2
        cfg_write(0, 0, 3, 2);
        start_frame(1, 1);
        run_frame("rnd3", 3, 32'h1, 6, 1, 1, 2, 0);
        start_frame(1, 1);
        run_frame("rnd2", 2, 32'h1, 6, 1, 1, 2, 0);
        start_frame(1, 1);
        run_frame("rnd1", 1, 32'h1, 6, 1, 1, 1, 0);
        start_frame(1, 1);
        run_frame("rnd_neg", -2, 32'h1, 6, 1, 1, ExpNegRnd, 0);

        // Per-channel bias, back-to-back then gapped with a surplus ninth input
        cfg_write(0, 0, 1, 0);
        cfg_write(1, 10, 1, 0);
        start_frame(2, 2);
        run_frame("chan", 1, 32'h0000_00ff, 14, 8, 2, 1, 11);
        start_frame(2, 2);
        run_frame("gap", 1, 32'h0001_5555, 24, 8, 2, 1, 11);

        // Empty frame completes immediately
        ofm_w    = 9'd0;
        out_ch   = 9'd1;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        check("zero_done", ap_done, 1);
        check("zero_busy", busy, 0);
        step();
        check("zero_done_end", ap_done, 0);

        // Reset mid-frame aborts without ap_done
        start_frame(2, 2);
        acc_vld_i = 1'b1;
        acc_i     = 1;
        step();
        check("ab_vld1", conv_kern_vld_o, 0);
        step();
        check("ab_vld2", conv_kern_vld_o, 0);
        step();
        check("ab_vld3", conv_kern_vld_o, 1);
        acc_vld_i = 1'b0;
        rst       = 1'b1;
        step();
        rst      = 1'b0;
        last_out = 0;
        check("ab_out", conv_kern_o, 0);
        check("ab_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            check("ab_novld", conv_kern_vld_o, 0);
            check("ab_nodone", ap_done, 0);
            step();
        end

        // Config writes outside IDLE are ignored
        start_frame(1, 1);
        cfg_we    = 1'b1;
        cfg_ch    = 6'd0;
        cfg_bias  = 50;
        cfg_mult  = 16'd2;
        cfg_shift = 5'd0;
        step();
        cfg_we = 1'b0;
        run_frame("guard_run", 5, 32'h1, 6, 1, 1, 5, 0);
        start_frame(1, 1);
        run_frame("guard_next", 5, 32'h1, 6, 1, 1, 5, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_requant_relu.md
Name: conv_requant_relu

Overview:
Upstream neighbour of output_feature_module. Takes the raw 32-bit convolution accumulator stream and applies a per-output-channel bias, a fixed-point multiplier and a rounding right-shift. It then applies ReLU and saturates the result to WI bits. The result drives conv_kern_o / conv_kern_vld_o directly, so one frame of ofm_w*ofm_w*out_ch values maps to one output_feature_module run.

Parameters:
ACC_W, 32, accumulator input width (signed)
WI, 8, output feature width (signed two's complement)
MULT_W, 16, per-channel multiplier width (unsigned)
SHIFT_W, 5, per-channel right-shift width
MAX_CH, 64, number of per-channel config entries; CH_AW = $clog2(MAX_CH)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ap_start  in  1  level; a 0->1 transition in IDLE starts a frame
ofm_w  in  9  output feature map width; sampled at start
out_ch  in  9  output channel count, 1..MAX_CH; sampled at start
cfg_we  in  1  per-channel config write strobe
cfg_ch  in  CH_AW  config entry index
cfg_bias  in  ACC_W  signed bias
cfg_mult  in  MULT_W  unsigned multiplier
cfg_shift  in  SHIFT_W  right-shift amount
acc_i  in  ACC_W  signed accumulator value
acc_vld_i  in  1  acc_i valid, one value per cycle, no backpressure
conv_kern_o  out  WI  requantised feature
conv_kern_vld_o  out  1  conv_kern_o valid
busy  out  1  high in RUN/DRAIN
ap_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters and pipeline valids cleared. Config RAM contents are not reset. Reset asserted mid-frame aborts the frame; no ap_done is produced for it.
- FSM states:
  - IDLE: on an ap_start rising edge, latch ofm_w and out_ch, compute total = ofm_w*ofm_w*out_ch (27-bit), clear counters, go to RUN. If total==0, go straight to DONE.
  - RUN: accept acc_i on each acc_vld_i. Once the input count reaches total, go to DRAIN; acc_vld_i is ignored from then on.
  - DRAIN: wait until the output count equals total, then go to DONE.
  - DONE: pulse ap_done for 1 cycle, then return to IDLE. A new start requires ap_start to deassert and reassert.
- Channel order: channel index is innermost. ch_cnt starts at 0, increments per accepted input, and wraps from out_ch-1 to 0.
- Config writes:
  - cfg_we is honoured only in IDLE and ignored elsewhere.
  - A write to cfg_ch >= MAX_CH is ignored.
- Pipeline, latency exactly 3 cycles from the acc_vld_i edge to conv_kern_vld_o:
  - S1: s1 = acc_i + bias[ch], 33-bit signed, no overflow.
  - S2: s2 = s1 * {0,mult[ch]}, 50-bit signed.
  - S3: rounding and output:
    - If shift > 0: r = (s2 + (1<<(shift-1))) >>> shift. If shift == 0: r = s2. Rounding is round-half-up.
    - Apply ReLU and saturate (see the optional feature), then register the result to conv_kern_o.
- conv_kern_o holds its last value when conv_kern_vld_o is low.
- Inputs in IDLE/DRAIN/DONE are dropped. ap_start held high during RUN has no effect.

Optional Feature:
Macro RELU_EN.
- Defined: negative r becomes 0 and the result clamps to 0..2^(WI-1)-1 (0..127).
- Undefined: no ReLU; the result clamps to -2^(WI-1)..2^(WI-1)-1 (-128..127).
- Latency is identical in both builds.

Decomposition:
- Package requant_pkg holds the following:
  - Width constants: ACC_W, WI, MULT_W, SHIFT_W.
  - The channel config struct {bias, mult, shift}.
  - The FSM state enum {IDLE, RUN, DRAIN, DONE}.
  - A saturate function.
- One sub-module, requant_cfg_ram: a MAX_CH-entry register file with a synchronous write port and a combinational read by ch_cnt.

Test Plan:
- Basic pass-through: cfg ch0 bias=0, mult=1, shift=0; ofm_w=1, out_ch=1; acc=5 -> conv_kern_o=5 with vld exactly 3 cycles later; ap_done pulses 1 cycle after that.
- Saturation: acc=1000 -> 127. acc=-7 -> 0 with RELU_EN, -7 without. acc=-1000 without RELU_EN -> -128.
- Rounding: mult=3, shift=2. acc=3 -> 2 (9/4=2.25). acc=2 -> 2 (6/4=1.5 rounds up). acc=1 -> 1 (0.75).
- Per-channel ordering: out_ch=2, ofm_w=2; bias ch0=0, ch1=10; mult=1; 8 inputs of acc=1 -> outputs 1,11,1,11,1,11,1,11; ap_done one cycle after the 8th valid.
- Gapped input and overflow input: same frame as above with acc_vld_i toggling every other cycle -> same 8 outputs. A 9th acc_vld_i produces no output.
- Reset and config guard: assert rst after 3 inputs -> vld stays low, no ap_done, FSM=IDLE. cfg_we during RUN -> the config is unchanged in the next frame.
